// File: rtl/seq_detector_multi.sv
// Runtime-programmable serial pattern detector with NUM_PAT slots of up to MAX_LEN bits.
// Optional per-slot saturating hit counters are built when SEQ_DET_HIT_CNT_EN is defined.
module seq_detector_multi #(
  parameter int NUM_PAT = 2,
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16,
  localparam int IDX_W  = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               clear,
  input  logic               overlap_en,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_en,
  output logic [NUM_PAT-1:0] hit_vec,
  output logic               detected
`ifdef SEQ_DET_HIT_CNT_EN
  ,
  output logic [NUM_PAT*CNT_W-1:0] hit_cnt
`endif
);

  if (NUM_PAT < 1 || MAX_LEN < 2 || CNT_W < 1) begin : g_bad_param
    $error("seq_detector_multi: illegal parameter set");
  end

  function automatic logic [MAX_LEN-1:0] dflt_pat(input int p);
    if (p == 0) return MAX_LEN'(6'b101101);
    if (p == 1) return MAX_LEN'(6'b101001);
    return '0;
  endfunction

  function automatic logic [LEN_W-1:0] dflt_len(input int p);
    return (p < 2) ? LEN_W'(6) : '0;
  endfunction

  // The oldest history bit is only ever consumed through hist_d, so MAX_LEN-1 bits are stored.
  logic [MAX_LEN-2:0] hist_q;
  logic [LEN_W-1:0]   fill_q;
  logic [NUM_PAT-1:0] hit_q;
  logic               det_q;
  logic [MAX_LEN-1:0] pat_q [NUM_PAT];
  logic [LEN_W-1:0]   len_q [NUM_PAT];
  logic [NUM_PAT-1:0] en_q;

  logic [MAX_LEN-1:0] hist_d;
  logic [LEN_W-1:0]   fill_d;
  logic [MAX_LEN-1:0] mask [NUM_PAT];
  logic [NUM_PAT-1:0] match;
  logic [LEN_W-1:0]   cfg_len_clamped;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    hist_d = {hist_q, in_bit};
    fill_d = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
    match  = '0;
    for (int p = 0; p < NUM_PAT; p++) begin
      mask[p] = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
        mask[p][i] = (i < int'(len_q[p]));
      end
      match[p] = in_valid && en_q[p] && (len_q[p] != '0) && (fill_d >= len_q[p])
                 && (((hist_d ^ pat_q[p]) & mask[p]) == '0);
    end
    cfg_len_clamped = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
  end

`ifdef SEQ_DET_HIT_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_PAT];

  for (genvar p = 0; p < NUM_PAT; p++) begin : g_cnt_out
    assign hit_cnt[p*CNT_W +: CNT_W] = cnt_q[p];
  end
`endif

  // NOTE: the config registers are a small register file, not RAM; they reset so the
  // block comes up with its default patterns loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
      hit_q  <= '0;
      det_q  <= 1'b0;
      for (int p = 0; p < NUM_PAT; p++) begin
        pat_q[p] <= dflt_pat(p);
        len_q[p] <= dflt_len(p);
        en_q[p]  <= (p < 2);
`ifdef SEQ_DET_HIT_CNT_EN
        cnt_q[p] <= '0;
`endif
      end
    end else begin
      // Config writes land independently of clear and of a beat in the same cycle.
      for (int p = 0; p < NUM_PAT; p++) begin
        if (cfg_we && int'(cfg_idx) == p) begin
          pat_q[p] <= cfg_pattern;
          len_q[p] <= cfg_len_clamped;
          en_q[p]  <= cfg_en;
        end
      end

      if (clear) begin
        hist_q <= '0;
        fill_q <= '0;
        hit_q  <= '0;
        det_q  <= 1'b0;
`ifdef SEQ_DET_HIT_CNT_EN
        for (int p = 0; p < NUM_PAT; p++) cnt_q[p] <= '0;
`endif
      end else if (in_valid) begin
        hist_q <= hist_d[MAX_LEN-2:0];
        fill_q <= (!overlap_en && (match != '0)) ? '0 : fill_d;
        hit_q  <= match;
        det_q  <= |match;
`ifdef SEQ_DET_HIT_CNT_EN
        for (int p = 0; p < NUM_PAT; p++) begin
          if (match[p] && cnt_q[p] != '1) cnt_q[p] <= cnt_q[p] + 1'b1;
        end
`endif
      end else begin
        hit_q <= '0;
        det_q <= 1'b0;
      end
    end
  end

  assign hit_vec  = hit_q;
  assign detected = det_q;

endmodule

// File: tb/tb_seq_detector_multi.sv
// Scoreboard bench for seq_detector_multi: a queue-of-bits reference model predicts every
// output cycle; directed scenarios also check hand-derived hit totals.
module tb_seq_detector_multi;

  localparam int NUM_PAT = 2;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int IDX_W   = 1;
  localparam int LEN_W   = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_bit = 1'b0;
  logic               clear = 1'b0;
  logic               overlap_en = 1'b1;
  logic               cfg_we = 1'b0;
  logic [IDX_W-1:0]   cfg_idx = '0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_en = 1'b0;
  logic [NUM_PAT-1:0] hit_vec;
  logic               detected;
`ifdef SEQ_DET_HIT_CNT_EN
  logic [NUM_PAT*CNT_W-1:0] hit_cnt;
`endif

  seq_detector_multi #(.NUM_PAT(NUM_PAT), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
    .overlap_en(overlap_en), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_en(cfg_en), .hit_vec(hit_vec), .detected(detected)
`ifdef SEQ_DET_HIT_CNT_EN
    , .hit_cnt(hit_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: received bits since the last restart, newest at the back.
  typedef struct {
    logic [NUM_PAT-1:0] hit;
    logic               det;
  } exp_t;

  bit                 hist_m [$];
  logic [MAX_LEN-1:0] pat_m [NUM_PAT];
  int                 len_m [NUM_PAT];
  bit                 en_m  [NUM_PAT];
  int                 cnt_m [NUM_PAT];
  exp_t               sb_q [$];
  int                 hits_obs [NUM_PAT];
  int                 both_obs;

  task automatic model_reset();
    hist_m.delete();
    sb_q.delete();
    pat_m[0] = 8'b0010_1101; len_m[0] = 6; en_m[0] = 1'b1; cnt_m[0] = 0;
    pat_m[1] = 8'b0010_1001; len_m[1] = 6; en_m[1] = 1'b1; cnt_m[1] = 0;
  endtask

  task automatic reset_obs();
    for (int p = 0; p < NUM_PAT; p++) hits_obs[p] = 0;
    both_obs = 0;
  endtask

  // One clock: predict from the driven inputs, clock, then compare against the scoreboard.
  task automatic tick();
    exp_t e;
    bit   ok;
    e.hit = '0;
    if (clear) begin
      hist_m.delete();
      for (int p = 0; p < NUM_PAT; p++) cnt_m[p] = 0;
    end else if (in_valid) begin
      hist_m.push_back(in_bit);
      if (hist_m.size() > MAX_LEN) void'(hist_m.pop_front());
      for (int p = 0; p < NUM_PAT; p++) begin
        if (en_m[p] && len_m[p] > 0 && hist_m.size() >= len_m[p]) begin
          ok = 1'b1;
          for (int i = 0; i < len_m[p]; i++)
            if (hist_m[hist_m.size() - 1 - i] != pat_m[p][i]) ok = 1'b0;
          e.hit[p] = ok;
          if (ok && cnt_m[p] < (1 << CNT_W) - 1) cnt_m[p]++;
        end
      end
      if (e.hit != '0 && !overlap_en) hist_m.delete();
    end
    e.det = |e.hit;
    if (cfg_we && int'(cfg_idx) < NUM_PAT) begin
      pat_m[cfg_idx] = cfg_pattern;
      len_m[cfg_idx] = (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
      en_m[cfg_idx]  = cfg_en;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("hit_vec", 64'(hit_vec), 64'(e.hit));
    check("detected", 64'(detected), 64'(e.det));
`ifdef SEQ_DET_HIT_CNT_EN
    for (int p = 0; p < NUM_PAT; p++)
      check("hit_cnt", 64'(hit_cnt[p*CNT_W +: CNT_W]), 64'(cnt_m[p]));
`endif
    for (int p = 0; p < NUM_PAT; p++) if (hit_vec[p]) hits_obs[p]++;
    if (&hit_vec) both_obs++;
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      in_valid = 1'b1;
      in_bit   = (s[i] == "1");
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic cfg(input int idx, input logic [MAX_LEN-1:0] pat, input int len, input bit en);
    cfg_we = 1'b1; cfg_idx = IDX_W'(idx); cfg_pattern = pat; cfg_len = LEN_W'(len); cfg_en = en;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    model_reset();
    reset_obs();
    #12;
    check("reset_hit", 64'(hit_vec), 64'd0);
    check("reset_det", 64'(detected), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    idle(1);

    // Default patterns, overlapping: slot0 after bit 6, slot1 after bit 9.
    overlap_en = 1'b1;
    send("101101");
    check("t1_slot0", 64'(hits_obs[0]), 64'd1);
    send("001");
    check("t1_slot1", 64'(hits_obs[1]), 64'd1);

    // Short pattern, overlap on then off.
    do_clear();
    cfg(0, 8'b101, 3, 1'b1);
    reset_obs();
    send("10101");
    check("t2_ovl", 64'(hits_obs[0]), 64'd2);
    do_clear();
    overlap_en = 1'b0;
    reset_obs();
    send("10101");
    check("t2_novl", 64'(hits_obs[0]), 64'd1);
    overlap_en = 1'b1;

    // Two slots completing on the same beat.
    cfg(0, 8'b10_1101, 6, 1'b1);
    cfg(1, 8'b1101, 4, 1'b1);
    do_clear();
    reset_obs();
    send("101101");
    check("t3_both", 64'(both_obs), 64'd1);
    check("t3_slot1", 64'(hits_obs[1]), 64'd1);

    // Gap in in_valid holds history.
    cfg(1, 8'b10_1001, 6, 1'b1);
    do_clear();
    reset_obs();
    send("101");
    idle(5);
    check("t4_gap", 64'(hits_obs[0] + hits_obs[1]), 64'd0);
    send("101");
    check("t4_after", 64'(hits_obs[0]), 64'd1);

    // clear beats a coincident 6th bit and restarts fill.
    do_clear();
    reset_obs();
    send("10110");
    in_valid = 1'b1; in_bit = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    send("01101");
    check("t5_clear", 64'(hits_obs[0]), 64'd0);

    // len 0 and disabled slot never hit; oversize length clamps to MAX_LEN.
    reset_obs();
    cfg(0, 8'b10_1101, 0, 1'b1);
    do_clear();
    send("101101");
    cfg(0, 8'b10_1101, 6, 1'b0);
    do_clear();
    send("101101");
    check("t6_off", 64'(hits_obs[0]), 64'd0);
    cfg(0, 8'hB6, 15, 1'b1);
    do_clear();
    send("10110110");
    check("t6_clamp", 64'(hits_obs[0]), 64'd1);

    // Beat with coincident config write uses the old config; clear+cfg both apply.
    cfg(0, 8'b10_1101, 6, 1'b1);
    do_clear();
    reset_obs();
    send("10110");
    in_valid = 1'b1; in_bit = 1'b1;
    cfg_we = 1'b1; cfg_idx = '0; cfg_pattern = 8'b10_1101; cfg_len = '0; cfg_en = 1'b1;
    tick();
    cfg_we = 1'b0; in_valid = 1'b0;
    check("t7_oldcfg", 64'(hits_obs[0]), 64'd1);
    send("101101");
    check("t7_newcfg", 64'(hits_obs[0]), 64'd1);
    clear = 1'b1; cfg_we = 1'b1; cfg_len = LEN_W'(6);
    tick();
    clear = 1'b0; cfg_we = 1'b0;
    send("101101");
    check("t7_clrcfg", 64'(hits_obs[0]), 64'd2);

    // Asynchronous reset mid-stream restores defaults immediately.
    cfg(1, 8'h0F, 4, 1'b1);
    send("101101");
    #2 rst_n = 1'b0;
    #1;
    check("arst_hit", 64'(hit_vec), 64'd0);
    check("arst_det", 64'(detected), 64'd0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    reset_obs();
    send("101001");
    check("arst_dflt", 64'(hits_obs[1]), 64'd1);

`ifdef SEQ_DET_HIT_CNT_EN
    // Counter saturation and clear.
    do_clear();
    overlap_en = 1'b0;
    reset_obs();
    repeat (5) send("101101");
    check("cnt_hits", 64'(hits_obs[0]), 64'd5);
    check("cnt_sat", 64'(hit_cnt[CNT_W-1:0]), 64'd3);
    do_clear();
    check("cnt_clr", 64'(hit_cnt[CNT_W-1:0]), 64'd0);
    overlap_en = 1'b1;
`endif

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
